// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a 256x16 block RAM: clears the RAM after reset, then grants one command per cycle.
// Define BRAM_ARB_FIXED_PRIO_EN to make A win every tie; the default build uses round-robin arbitration.
module bram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] a_mask,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [DATA_W-1:0] b_mask,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_mask,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              init_done
);

  // state | meaning
  // CLEAR | writing zero to every RAM word, requests held off
  // RUN   | arbitrating A/B commands onto the RAM
  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              tag_valid_q, tag_b_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_win, b_win, a_pref;
  logic              win_we;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign a_pref = 1'b1;
`else
  logic last_b_q;

  // Starts at B so A takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst)                last_b_q <= 1'b1;
    else if (a_win | b_win) last_b_q <= b_win;
  end

  assign a_pref = last_b_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_b_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_valid_q <= ram_re;
      tag_b_q     <= b_win;
      if (a_rvalid) a_rdata_q <= ram_rdata;
      if (b_rvalid) b_rdata_q <= ram_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_win     = 1'b0;
    b_win     = 1'b0;
    win_we    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    ram_wdata = '0;
    ram_mask  = '0;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          ram_we    = 1'b1;
          ram_waddr = cnt_q;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          a_win     = a_req & (~b_req | a_pref);
          b_win     = b_req & ~a_win;
          win_we    = b_win ? b_we : a_we;
          ram_we    = (a_win | b_win) & win_we;
          ram_re    = (a_win | b_win) & ~win_we;
          ram_waddr = b_win ? b_addr : a_addr;
          ram_raddr = b_win ? b_addr : a_addr;
          ram_wdata = b_win ? b_wdata : a_wdata;
          ram_mask  = b_win ? b_mask : a_mask;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  assign a_gnt     = a_win;
  assign b_gnt     = b_win;
  assign init_done = ~rst & (state_q == RUN);

  // Reset gates the tag so a read granted just before reset never returns.
  assign a_rvalid = ~rst & tag_valid_q & ~tag_b_q;
  assign b_rvalid = ~rst & tag_valid_q & tag_b_q;
  assign a_rdata  = rst ? '0 : (a_rvalid ? ram_rdata : a_rdata_q);
  assign b_rdata  = rst ? '0 : (b_rvalid ? ram_rdata : b_rdata_q);

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word address width matching the 256x16 block-RAM mode.
REQ-002 Parameter DATA_W, default 16, data and mask width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state and for the attached RAM's WCLK/RCLK.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 a_req  in  1  requester A command valid; held with its fields until a_gnt.
REQ-007 a_we  in  1  1 = write, 0 = read.
REQ-008 a_addr  in  ADDR_W  word address.
REQ-009 a_wdata  in  DATA_W  write data.
REQ-010 a_mask  in  DATA_W  per-bit write mask; 1 = bit not written; passed through unchanged.
REQ-011 a_gnt  out  1  command accepted this cycle.
REQ-012 a_rvalid  out  1  read data valid for A.
REQ-013 a_rdata  out  DATA_W  read data for A.
REQ-014 b_req, b_we, b_addr, b_wdata, b_mask, b_gnt, b_rvalid, b_rdata: same directions, widths and meanings for requester B.
REQ-015 ram_we / ram_re  out  1 each  RAM write / read enable; WCLKE and RCLKE are tied high outside this block.
REQ-016 ram_waddr / ram_raddr  out  ADDR_W each  RAM write / read address.
REQ-017 ram_wdata / ram_mask  out  DATA_W each  RAM write data / write mask.
REQ-018 ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re.
REQ-019 init_done  out  1  high once the post-reset clear has finished.

Function
REQ-020 States: CLEAR and RUN; the block enters CLEAR on reset.
REQ-021 CLEAR: the block drives ram_we=1, ram_waddr=clear counter, ram_wdata=0 and ram_mask=0 every cycle, with the counter running 0..2^ADDR_W-1 and gnt held low.
REQ-022 On the cycle after the counter-max write, the block enters RUN, sets init_done=1 and sets the counter to 0.
REQ-023 RUN: at most one command per cycle; a_gnt/b_gnt are combinational in the same cycle the command drives the RAM.
REQ-024 The granted command drives ram_we=we and ram_re=~we; the addresses, wdata and mask are taken from the winner; with no request, ram_we=ram_re=0.
REQ-025 Arbitration is round-robin: a single requester wins; if both request, the winner is the one not served last; the last-served pointer updates on every grant.
REQ-026 A granted read sets a registered tag (valid plus owner); next cycle the owner's rvalid=1 and its rdata=ram_rdata; the other requester's rvalid=0.
REQ-027 The non-owner's rdata holds its last value.
REQ-028 Throughput is one command per cycle, back-to-back reads included; read latency is exactly 1 cycle after gnt.
REQ-029 A read and a write to the same address in consecutive cycles return RAM-native data; the block provides no forwarding.
REQ-030 Requests seen during CLEAR are neither granted nor dropped; they are granted in RUN.

Reset
REQ-031 While rst=1: the block is in CLEAR with counter=0, init_done=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0 and the read tag invalid.
REQ-032 While rst=1 the last-served pointer is B, so A wins the first tie.
REQ-033 While rst=1, ram_we=ram_re=0.
REQ-034 Reset mid-operation discards any in-flight read without asserting rvalid and restarts the clear from address 0.

Configuration
REQ-035 With macro BRAM_ARB_FIXED_PRIO_EN defined, A always wins a tie and the last-served pointer is absent.
REQ-036 Without BRAM_ARB_FIXED_PRIO_EN, round-robin per REQ-025 applies.

Verification
REQ-037 Release rst -> 256 consecutive cycles of ram_we=1 with addresses 0x00..0xFF and wdata=0; init_done rises on the next cycle.
REQ-038 A writes 0xBEEF to 0x12 with mask 0x0000, then A reads 0x12 -> a_rvalid=1 with a_rdata=0xBEEF one cycle after the read gnt.
REQ-039 A and B both hold reads for 4 cycles -> grants go A,B,A,B (A,A,A,A with BRAM_ARB_FIXED_PRIO_EN); each rvalid reaches only the owner.
REQ-040 Write 0xFFFF to 0x40 with mask 0x00FF -> a read of 0x40 returns 0xFF00.
REQ-041 Assert rst the cycle after a B read grant -> b_rvalid stays 0 and the clear restarts at 0x00.
